// File: rtl/sr_window_gen_pkg.sv
// Shared primitives for the SR window generator.
//   sr_state_e : controller state encoding (IDLE / RUN / ABORT)
//   CNT_W_DEF  : default width of the position/length counter
package sr_window_gen_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ABORT = 2'd2
  } sr_state_e;

endpackage

// File: rtl/sr_window_gen_pos_match.sv
// sr_pos_match: compares a counter value against the set/reset positions.
// Ports:
//   cnt_i      counter value being evaluated
//   set_pos_i  position at which S fires
//   rst_pos_i  position at which R fires
//   len_i      period length; positions >= len_i never fire
//   s_o, r_o   combinational match flags; never both 1
module sr_pos_match #(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] set_pos_i,
  input  logic [CNT_W-1:0] rst_pos_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             s_o,
  output logic             r_o
);

  // Equal positions would ask the latch for S=R=1; suppress both instead.
  logic legal;
  assign legal = (set_pos_i != rst_pos_i);

  assign s_o = legal && (set_pos_i < len_i) && (cnt_i == set_pos_i);
  assign r_o = legal && (rst_pos_i < len_i) && (cnt_i == rst_pos_i);

endmodule

// File: rtl/sr_window_gen.sv
// sr_window_gen: generates one S and one R pulse per period for a
// downstream SR latch, with single/continuous mode and abort.
// Ports:
//   i_CLK, i_RST_n   clock, async active-low reset
//   i_CEN_n          active-low clock enable; all state holds when 1
//   i_START          start request (IDLE only)
//   i_ABORT          abort request (RUN only; forces one R pulse)
//   i_REPEAT         continue into a new period at wrap
//   i_LEN            period length in enabled cycles
//   i_SET_POS        counter value for o_S
//   i_RST_POS        counter value for o_R
//   o_S, o_R         registered set/reset pulses
//   o_BUSY           high in RUN and ABORT
//   o_DONE           one enabled-cycle completion strobe
module sr_window_gen
  import sr_window_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_CEN_n,
  input  logic             i_START,
  input  logic             i_ABORT,
  input  logic             i_REPEAT,
  input  logic [CNT_W-1:0] i_LEN,
  input  logic [CNT_W-1:0] i_SET_POS,
  input  logic [CNT_W-1:0] i_RST_POS,
  output logic             o_S,
  output logic             o_R,
  output logic             o_BUSY,
  output logic             o_DONE
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] rstp_q, rstp_d;
  logic             s_q, s_d, r_q, r_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic run_nxt;   // next cycle is a RUN cycle whose position may fire
  logic abort_r;   // entering ABORT: emit the forced R pulse
  logic m_s, m_r;

  // Outputs are registered, so the match is evaluated on the *next*
  // counter/config values; a position-0 pulse then appears on the
  // first cycle after START.
  sr_pos_match #(.CNT_W(CNT_W)) u_match (
    .cnt_i    (cnt_d),
    .set_pos_i(set_d),
    .rst_pos_i(rstp_d),
    .len_i    (len_d),
    .s_o      (m_s),
    .r_o      (m_r)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    set_d   = set_q;
    rstp_d  = rstp_q;
    done_d  = 1'b0;
    run_nxt = 1'b0;
    abort_r = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_START) begin
          if (i_LEN != '0) begin
            len_d   = i_LEN;
            set_d   = i_SET_POS;
            rstp_d  = i_RST_POS;
            cnt_d   = '0;
            state_d = ST_RUN;
            run_nxt = 1'b1;
          end else begin
            done_d = 1'b1;   // empty period completes immediately
          end
        end
      end
      ST_RUN: begin
        if (i_ABORT) begin
          state_d = ST_ABORT;
          cnt_d   = '0;
          abort_r = 1'b1;
        end else if (cnt_q == len_q - CNT_ONE) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // A zero length on reload cannot form a period; finish instead.
          if (i_REPEAT && (i_LEN != '0)) begin
            len_d   = i_LEN;
            set_d   = i_SET_POS;
            rstp_d  = i_RST_POS;
            run_nxt = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          run_nxt = 1'b1;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    s_d    = run_nxt & m_s;
    r_d    = abort_r | (run_nxt & m_r);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      set_q   <= '0;
      rstp_q  <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!i_CEN_n) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      set_q   <= set_d;
      rstp_q  <= rstp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_S    = s_q;
  assign o_R    = r_q;
  assign o_BUSY = busy_q;
  assign o_DONE = done_q;

endmodule

// File: tb/tb_sr_window_gen.sv
// Scoreboard bench for sr_window_gen. Expected {S,R,BUSY,DONE} vectors are
// queued as each cycle is driven and popped after the clock edge.
module tb_sr_window_gen;

  localparam int CNT_W = 8;

  logic             i_CLK = 1'b0;
  logic             i_RST_n, i_CEN_n, i_START, i_ABORT, i_REPEAT;
  logic [CNT_W-1:0] i_LEN, i_SET_POS, i_RST_POS;
  logic             o_S, o_R, o_BUSY, o_DONE;
  logic [3:0]       obs;

  sr_window_gen #(.CNT_W(CNT_W)) dut (
    .i_CLK    (i_CLK),
    .i_RST_n  (i_RST_n),
    .i_CEN_n  (i_CEN_n),
    .i_START  (i_START),
    .i_ABORT  (i_ABORT),
    .i_REPEAT (i_REPEAT),
    .i_LEN    (i_LEN),
    .i_SET_POS(i_SET_POS),
    .i_RST_POS(i_RST_POS),
    .o_S      (o_S),
    .o_R      (o_R),
    .o_BUSY   (o_BUSY),
    .o_DONE   (o_DONE)
  );

  always #5 i_CLK = ~i_CLK;
  assign obs = {o_S, o_R, o_BUSY, o_DONE};

  int         n_vec = 0;
  int         n_err = 0;
  int         gap   = 0;     // disabled cycles inserted before each enabled one
  logic [3:0] last_exp = 4'b0000;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got SRBD=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs of a RUN cycle at counter c.
  function automatic logic [3:0] pos_exp(input int c, input int len, input int sp, input int rp);
    logic s, r;
    s = (c == sp) && (sp != rp) && (sp < len);
    r = (c == rp) && (sp != rp) && (rp < len);
    return {s, r, 1'b1, 1'b0};
  endfunction

  // One enabled cycle, preceded by 'gap' disabled cycles with junk on
  // START/ABORT that must be ignored while outputs hold.
  task automatic en_cyc(input logic st, input logic ab, input logic [3:0] e, input string tag);
    for (int g = 0; g < gap; g++) begin
      i_CEN_n = 1'b1;
      i_START = 1'($urandom_range(0, 1));
      i_ABORT = 1'($urandom_range(0, 1));
      exp_q.push_back(last_exp);
      @(posedge i_CLK); #1;
      chk({tag, "_hold"}, obs, exp_q.pop_front());
    end
    i_CEN_n = 1'b0;
    i_START = st;
    i_ABORT = ab;
    exp_q.push_back(e);
    last_exp = e;
    @(posedge i_CLK); #1;
    chk(tag, obs, exp_q.pop_front());
    i_START = 1'b0;
    i_ABORT = 1'b0;
  endtask

  // START, run 'periods' periods (REPEAT held until the last), then DONE.
  task automatic run_cfg(input int len, input int sp, input int rp, input int periods, input string tag);
    logic [3:0] e;
    i_LEN     = CNT_W'(len);
    i_SET_POS = CNT_W'(sp);
    i_RST_POS = CNT_W'(rp);
    i_REPEAT  = (periods > 1);
    for (int p = 0; p < periods; p++) begin
      for (int c = 0; c < len; c++) begin
        e    = pos_exp(c, len, sp, rp);
        e[0] = (c == 0) && (p > 0);
        en_cyc((p == 0) && (c == 0), 1'b0, e, $sformatf("%s_p%0d_c%0d", tag, p, c));
        if (p == periods - 1) i_REPEAT = 1'b0;
      end
    end
    en_cyc(1'b0, 1'b0, 4'b0001, {tag, "_done"});
    en_cyc(1'b0, 1'b0, 4'b0000, {tag, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    i_RST_n = 1'b0; i_CEN_n = 1'b0; i_START = 1'b0; i_ABORT = 1'b0;
    i_REPEAT = 1'b0; i_LEN = '0; i_SET_POS = '0; i_RST_POS = '0;
    repeat (2) @(posedge i_CLK);
    #1;
    exp_q.push_back(4'b0000);
    chk("reset_state", obs, exp_q.pop_front());
    i_RST_n = 1'b1;

    // abort while idle is ignored
    en_cyc(1'b0, 1'b1, 4'b0000, "idle_abort");

    // basic single period: S at cycle 3, R at 6, DONE at 9
    run_cfg(8, 2, 5, 1, "basic");

    // same config with one enabled edge in three
    gap = 2;
    run_cfg(8, 2, 5, 1, "cen");
    gap = 0;

    // equal positions: neither fires, DONE still
    run_cfg(8, 4, 4, 1, "eqpos");

    // set position out of range never fires
    run_cfg(8, 9, 5, 1, "oor");

    // zero length: DONE only, never BUSY
    i_LEN = '0; i_SET_POS = 8'd0; i_RST_POS = 8'd1;
    en_cyc(1'b1, 1'b0, 4'b0001, "len0_done");
    en_cyc(1'b0, 1'b0, 4'b0000, "len0_idle");

    // abort at counter 3 (START asserted too, must be ignored)
    i_LEN = 8'd10; i_SET_POS = 8'd2; i_RST_POS = 8'd7; i_REPEAT = 1'b0;
    for (int c = 0; c < 4; c++)
      en_cyc(c == 0, 1'b0, pos_exp(c, 10, 2, 7), $sformatf("abort_c%0d", c));
    en_cyc(1'b1, 1'b1, 4'b0110, "abort_r");
    en_cyc(1'b1, 1'b0, 4'b0001, "abort_done");
    en_cyc(1'b0, 1'b0, 4'b0000, "abort_idle");

    // continuous mode, 3 periods, S at counter 0
    run_cfg(4, 0, 2, 3, "rep");

    // reset mid-period in continuous mode
    i_LEN = 8'd4; i_SET_POS = 8'd0; i_RST_POS = 8'd2; i_REPEAT = 1'b1;
    for (int c = 0; c < 3; c++)
      en_cyc(c == 0, 1'b0, pos_exp(c, 4, 0, 2), $sformatf("rstrun_c%0d", c));
    #2;
    i_CEN_n = 1'b1;
    i_RST_n = 1'b0;
    #1;
    exp_q.push_back(4'b0000);
    chk("rst_async", obs, exp_q.pop_front());
    @(posedge i_CLK); #1;
    exp_q.push_back(4'b0000);
    chk("rst_held", obs, exp_q.pop_front());
    i_RST_n  = 1'b1;
    last_exp = 4'b0000;
    en_cyc(1'b0, 1'b0, 4'b0000, "post_rst_idle");
    run_cfg(4, 1, 3, 1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
